// File: rtl/register_file_2r1w_pkg.sv
// Shared CPU constants and the dump sequencer state type.
// Imported by the register file, its dump sequencer and the bench.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } dump_state_t;

endpackage

// File: rtl/register_file_2r1w_if.sv
// Debug-dump stream bundle: start pulse, valid/ready beat, status.
// The sequencer drives it as master; the consumer side is the slave.
interface register_file_2r1w_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              start;
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] index;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic              done;

  modport master (
    input  start,
    input  ready,
    output valid,
    output index,
    output data,
    output busy,
    output done
  );

  modport slave (
    output start,
    output ready,
    input  valid,
    input  index,
    input  data,
    input  busy,
    input  done
  );

endinterface

// File: rtl/register_file_2r1w_dump_seq.sv
// Dump FSM: streams every register in index order over valid/ready.
// Presented data tracks writes so a stalled beat is never stale.
module regfile_dump_seq
  import cpu_pkg::*;
#(
  parameter int DATA_W   = XLEN,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  register_file_2r1w_if.master dmp,
  output logic [ADDR_W-1:0]    o_rd_idx,
  input  logic [DATA_W-1:0]    i_rd_data,
  input  logic                 i_we,
  input  logic [ADDR_W-1:0]    i_waddr,
  input  logic [DATA_W-1:0]    i_wdata
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  dump_state_t       r_state, w_state;
  logic [ADDR_W-1:0] r_idx, w_idx;
  logic [DATA_W-1:0] r_data, w_data;
  logic              r_valid, w_valid;
  logic              r_busy, w_busy;
  logic              w_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_data  <= w_data;
      r_valid <= w_valid;
      r_busy  <= w_busy;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_idx    = r_idx;
    w_data   = r_data;
    w_valid  = r_valid;
    w_busy   = r_busy;
    w_acc    = r_valid & dmp.ready;
    o_rd_idx = r_idx + 1'b1;
    unique case (r_state)
      IDLE: begin
        if (dmp.start) begin
          w_state = SCAN;
          w_idx   = '0;
          w_data  = '0;
          w_valid = 1'b1;
          w_busy  = 1'b1;
        end
      end
      SCAN: begin
        if (w_acc) begin
          if (r_idx == LAST) begin
            w_state = DONE;
            w_valid = 1'b0;
          end else begin
            w_idx  = o_rd_idx;
            w_data = i_rd_data;
          end
        end else if (i_we && i_waddr == r_idx && r_idx != '0) begin
          w_data = i_wdata;
        end
      end
      DONE: begin
        w_state = IDLE;
        w_busy  = 1'b0;
      end
      default: w_state = IDLE;
    endcase
  end

  assign dmp.valid = r_valid;
  assign dmp.index = r_idx;
  assign dmp.data  = r_data;
  assign dmp.busy  = r_busy;
  assign dmp.done  = (r_state == DONE);

endmodule

// File: rtl/register_file_2r1w.sv
// 32-entry 2-read/1-write register file, x0 hardwired to zero,
// with write-through bypass on all read paths and a debug dump stream.
module register_file_2r1w
  import cpu_pkg::*;
#(
  parameter int DATA_W   = XLEN,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_register,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_register_1,
  input  logic [ADDR_W-1:0] read_register_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  input  logic              dump_start,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_index,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy,
  output logic              dump_done
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [ADDR_W-1:0] w_dump_idx;
  logic [DATA_W-1:0] w_dump_rd;

  register_file_2r1w_if #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) w_dmp ();

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_regs <= '{default: '0};
    end else if (write_enable && write_register != '0) begin
      r_regs[write_register] <= write_data;
    end
  end

  function automatic logic [DATA_W-1:0] rd_byp(
    input logic [ADDR_W-1:0] a
  );
    if (a == '0)
      return '0;
    if (write_enable && write_register == a)
      return write_data;
    return r_regs[a];
  endfunction

  always_comb begin
    read_data_1 = rd_byp(read_register_1);
    read_data_2 = rd_byp(read_register_2);
    w_dump_rd   = rd_byp(w_dump_idx);
  end

  regfile_dump_seq #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_dump (
    .clk      (clk),
    .rst_n    (reset),
    .dmp      (w_dmp.master),
    .o_rd_idx (w_dump_idx),
    .i_rd_data(w_dump_rd),
    .i_we     (write_enable),
    .i_waddr  (write_register),
    .i_wdata  (write_data)
  );

  assign w_dmp.start = dump_start;
  assign w_dmp.ready = dump_ready;
  assign dump_valid  = w_dmp.valid;
  assign dump_index  = w_dmp.index;
  assign dump_data   = w_dmp.data;
  assign dump_busy   = w_dmp.busy;
  assign dump_done   = w_dmp.done;

endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed bench for register_file_2r1w: reset, read/write, bypass,
// full dump, backpressure with write, and reset mid-dump.
module tb_register_file_2r1w;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  wr;
  logic [31:0] wd;
  logic [4:0]  rr1, rr2;
  logic [31:0] rd1, rd2;
  int          n_cmp = 0;
  int          n_bad = 0;

  register_file_2r1w_if #(.DATA_W(32), .ADDR_W(5)) dif ();

  register_file_2r1w dut (
    .clk            (clk),
    .reset          (reset),
    .write_enable   (we),
    .write_register (wr),
    .write_data     (wd),
    .read_register_1(rr1),
    .read_register_2(rr2),
    .read_data_1    (rd1),
    .read_data_2    (rd2),
    .dump_start     (dif.start),
    .dump_valid     (dif.valid),
    .dump_ready     (dif.ready),
    .dump_index     (dif.index),
    .dump_data      (dif.data),
    .dump_busy      (dif.busy),
    .dump_done      (dif.done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(dif.valid), 32'd0);
    chk({tag, "_busy"},  32'(dif.busy),  32'd0);
    chk({tag, "_done"},  32'(dif.done),  32'd0);
    chk({tag, "_index"}, 32'(dif.index), 32'd0);
    chk({tag, "_data"},  dif.data,       32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    we        = 1'b0;
    wr        = '0;
    wd        = '0;
    rr1       = '0;
    rr2       = '0;
    dif.start = 1'b0;
    dif.ready = 1'b0;
    tick;
    tick;
    chk_idle("rst");
    reset = 1'b1;
    rr1 = 5'd7;
    rr2 = 5'd0;
    #1;
    chk("rst_rd1", rd1, 32'd0);
    chk("rst_rd2", rd2, 32'd0);

    we = 1'b1; wr = 5'd5; wd = 32'hDEADBEEF;
    tick;
    we = 1'b0; rr1 = 5'd5;
    #1;
    chk("wr5_rd", rd1, 32'hDEADBEEF);

    we = 1'b1; wr = 5'd0; wd = 32'h1234; rr1 = 5'd0;
    #1;
    chk("wr0_nobyp", rd1, 32'd0);
    tick;
    we = 1'b0;
    #1;
    chk("wr0_rd", rd1, 32'd0);

    we = 1'b1; wr = 5'd9; wd = 32'hA5A5A5A5; rr2 = 5'd9;
    #1;
    chk("byp_rd2", rd2, 32'hA5A5A5A5);
    tick;
    we = 1'b0;
    #1;
    chk("byp_held", rd2, 32'hA5A5A5A5);

    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wr = i[4:0]; wd = i * 32'h10;
      tick;
    end
    we = 1'b0;

    dif.start = 1'b1;
    tick;
    dif.start = 1'b0;
    dif.ready = 1'b1;
    for (int b = 0; b < 32; b++) begin
      chk("dmp_valid", 32'(dif.valid), 32'd1);
      chk("dmp_busy",  32'(dif.busy),  32'd1);
      chk("dmp_index", 32'(dif.index), 32'(b));
      chk("dmp_data",  dif.data,       b * 32'h10);
      tick;
    end
    chk("done_hi",    32'(dif.done),  32'd1);
    chk("done_valid", 32'(dif.valid), 32'd0);
    chk("done_busy",  32'(dif.busy),  32'd1);
    tick;
    chk("post_done", 32'(dif.done), 32'd0);
    chk("post_busy", 32'(dif.busy), 32'd0);
    dif.ready = 1'b0;

    dif.start = 1'b1;
    tick;
    dif.start = 1'b0;
    dif.ready = 1'b1;
    tick;
    tick;
    tick;
    dif.ready = 1'b0;
    chk("bp_idx3",  32'(dif.index), 32'd3);
    chk("bp_dat3",  dif.data,       32'h30);
    we = 1'b1; wr = 5'd3; wd = 32'h77;
    tick;
    we = 1'b0;
    chk("bp_wr_idx", 32'(dif.index), 32'd3);
    chk("bp_wr_dat", dif.data,       32'h77);
    dif.start = 1'b1;
    tick;
    dif.start = 1'b0;
    chk("bp_st_idx", 32'(dif.index), 32'd3);
    chk("bp_st_vld", 32'(dif.valid), 32'd1);
    dif.ready = 1'b1;
    tick;
    chk("bp_adv_idx", 32'(dif.index), 32'd4);
    chk("bp_adv_dat", dif.data,       32'h40);
    repeat (8) tick;
    chk("mid_idx12", 32'(dif.index), 32'd12);
    chk("mid_dat12", dif.data,       32'hC0);

    reset = 1'b0;
    #1;
    chk_idle("arst");
    tick;
    reset = 1'b1;
    dif.ready = 1'b0;
    rr1 = 5'd12;
    rr2 = 5'd31;
    #1;
    chk("arst_rd12", rd1, 32'd0);
    chk("arst_rd31", rd2, 32'd0);
    tick;
    chk_idle("arst_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
